// File: rtl/route_interlock_ctrl_pkg.sv
// Shared types and helpers for the station-throat interlock.
package train_pkg;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RELEASE,
    S_THROW,
    S_RESP
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Slot number: left-side approaches first, then right-side.
  function automatic int slot_idx(input logic side, input int appr, input int num_appr);
    return (side ? num_appr : 0) + appr;
  endfunction

endpackage

// File: rtl/route_interlock_ctrl_conflict.sv
// Combinational conflict mask of a candidate route against the active table.
module route_conflict_check
  import train_pkg::*;
#(
  parameter int NUM_APPROACH = 2,
  parameter int NUM_STATION  = 4,
  localparam int AW    = width_of(NUM_APPROACH),
  localparam int SW    = width_of(NUM_STATION),
  localparam int NSLOT = 2 * NUM_APPROACH
)(
  input  logic [NSLOT-1:0]         active,
  input  logic [NSLOT-1:0][SW-1:0] station,
  input  logic                     cand_side,
  input  logic [AW-1:0]            cand_appr,
  input  logic [SW-1:0]            cand_stn,
  output logic [NSLOT-1:0]         mask
);

  // Same-side active routes sharing an approach, a station, or crossing paths.
  always_comb begin
    int a, s, b, t;
    logic same_side;
    mask = '0;
    a = int'(cand_appr);
    s = int'(cand_stn);
    for (int i = 0; i < NSLOT; i++) begin
      b = i % NUM_APPROACH;
      t = int'(station[i]);
      same_side = ((i >= NUM_APPROACH) == cand_side);
      mask[i] = active[i] && same_side &&
                ((a == b) || (s == t) || ((a < b) && (s > t)) || ((a > b) && (s < t)));
    end
  end

endmodule

// File: rtl/route_interlock_ctrl.sv
// Route-setting controller: conflict check, preemption/rejection, approach
// locking on release, switch throw timing, and registered table outputs.
module route_interlock_ctrl
  import train_pkg::*;
#(
  parameter int NUM_STATION    = 4,
  parameter int NUM_APPROACH   = 2,
  parameter int THROW_CYCLES   = 50000000,
  parameter int RELEASE_CYCLES = 100000000,
  parameter int PREEMPT        = 1,
  localparam int AW    = width_of(NUM_APPROACH),
  localparam int SW    = width_of(NUM_STATION),
  localparam int NSLOT = 2 * NUM_APPROACH,
  localparam int SLW   = width_of(NSLOT),
  localparam int CW    = $clog2(max_int(THROW_CYCLES, RELEASE_CYCLES) + 1)
)(
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_cancel,
  input  logic                  req_side,
  input  logic [AW-1:0]         req_approach,
  input  logic [SW-1:0]         req_station,
  output logic                  resp_valid,
  output logic                  resp_granted,
  output logic [NSLOT-1:0]      route_active,
  output logic [NSLOT*SW-1:0]   route_station,
  output logic [NSLOT-1:0]      signal_clear,
  output logic                  busy
);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q;
  logic                    r_cancel, r_side;
  logic [AW-1:0]           r_appr;
  logic [SW-1:0]           r_stn;
  logic                    grant_q;
  logic [NSLOT-1:0]        victim_q;
  logic [NSLOT-1:0]        act_q, act_d, clr_q, clr_d;
  logic [NSLOT-1:0][SW-1:0] stn_q, stn_d;

  logic                    req_ok;
  logic [SLW-1:0]          slot;
  logic [NSLOT-1:0]        slot_oh;
  logic [NSLOT-1:0]        conflict;
  logic [NSLOT-1:0]        chk_victim;
  logic                    chk_grant;

  route_conflict_check #(
    .NUM_APPROACH (NUM_APPROACH),
    .NUM_STATION  (NUM_STATION)
  ) u_conflict (
    .active    (act_q),
    .station   (stn_q),
    .cand_side (r_side),
    .cand_appr (r_appr),
    .cand_stn  (r_stn),
    .mask      (conflict)
  );

  // Validate the latched request and locate its slot (station ignored on cancel).
  always_comb begin
    req_ok  = (int'(r_appr) < NUM_APPROACH) && (r_cancel || (int'(r_stn) < NUM_STATION));
    slot    = req_ok ? SLW'(slot_idx(r_side, int'(r_appr), NUM_APPROACH)) : '0;
    slot_oh = '0;
    slot_oh[slot] = 1'b1;
  end

  // FSM state and dwell counter; counter reloads whenever a new state is entered.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        case (state_d)
          S_RELEASE: cnt_q <= CW'(RELEASE_CYCLES);
          S_THROW:   cnt_q <= CW'(THROW_CYCLES);
          default:   cnt_q <= '0;
        endcase
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Next-state logic and the CHECK-cycle decision (grant, victims).
  always_comb begin
    state_d    = state_q;
    chk_victim = '0;
    chk_grant  = 1'b0;
    case (state_q)
      S_IDLE: if (req_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (!req_ok) begin
          state_d = S_RESP;
        end else if (r_cancel) begin
          if (act_q[slot]) begin
            chk_victim = slot_oh;
            chk_grant  = 1'b1;
            state_d    = S_RELEASE;
          end else begin
            state_d = S_RESP;
          end
        end else if (act_q[slot] && (stn_q[slot] == r_stn)) begin
          chk_grant = 1'b1;
          state_d   = S_RESP;
        end else if (conflict == '0) begin
          chk_grant = 1'b1;
          state_d   = S_THROW;
        end else if (PREEMPT != 0) begin
          chk_victim = conflict;
          chk_grant  = 1'b1;
          state_d    = S_RELEASE;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RELEASE: if (cnt_q == CW'(1)) state_d = r_cancel ? S_RESP : S_THROW;
      S_THROW:   if (cnt_q == CW'(1)) state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Route table updates keyed on state transitions; victims free before the new slot is claimed.
  always_comb begin
    act_d = act_q;
    stn_d = stn_q;
    clr_d = clr_q;
    if (state_q == S_CHECK && state_d == S_RELEASE) clr_d = clr_q & ~chk_victim;
    if (state_q == S_RELEASE && state_d != S_RELEASE) act_d = act_q & ~victim_q;
    if (state_q != S_THROW && state_d == S_THROW) begin
      act_d[slot] = 1'b1;
      stn_d[slot] = r_stn;
    end
    if (state_q == S_THROW && state_d == S_RESP) clr_d[slot] = 1'b1;
  end

  // Request latch, decision capture and table registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_cancel <= 1'b0;
      r_side   <= LEFT;
      r_appr   <= '0;
      r_stn    <= '0;
      grant_q  <= 1'b0;
      victim_q <= '0;
      act_q    <= '0;
      stn_q    <= '0;
      clr_q    <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        r_cancel <= req_cancel;
        r_side   <= req_side;
        r_appr   <= req_approach;
        r_stn    <= req_station;
      end
      if (state_q == S_CHECK) begin
        grant_q  <= chk_grant;
        victim_q <= chk_victim;
      end
      act_q <= act_d;
      stn_q <= stn_d;
      clr_q <= clr_d;
    end
  end

  // Output register stage: every port is a flop, none sees req_* combinationally.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      route_active  <= '0;
      route_station <= '0;
      signal_clear  <= '0;
      resp_valid    <= 1'b0;
      resp_granted  <= 1'b0;
      req_ready     <= 1'b1;
      busy          <= 1'b0;
    end else begin
      route_active  <= act_q;
      route_station <= stn_q;
      signal_clear  <= clr_q;
      resp_valid    <= (state_q == S_RESP);
      resp_granted  <= (state_q == S_RESP) && grant_q;
      req_ready     <= (state_d == S_IDLE);
      busy          <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_route_interlock_ctrl.sv
// Directed bench: responses checked by scoreboard monitors, table state checked at fixed cycles.
module tb_route_interlock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req_valid  [2];
  logic       req_cancel [2];
  logic       req_side   [2];
  logic       req_appr   [2];
  logic [2:0] req_stn    [2];

  logic        rdy_p, rv_p, rg_p, busy_p;
  logic [3:0]  ra_p, sc_p;
  logic [7:0]  rs_p;
  logic        rdy_n, rv_n, rg_n, busy_n;
  logic [3:0]  ra_n, sc_n;
  logic [11:0] rs_n;

  route_interlock_ctrl #(
    .NUM_STATION(4), .NUM_APPROACH(2), .THROW_CYCLES(4), .RELEASE_CYCLES(3), .PREEMPT(1)
  ) dut_p (
    .CLOCK_50(clk), .RESET(rst),
    .req_valid(req_valid[0]), .req_ready(rdy_p), .req_cancel(req_cancel[0]),
    .req_side(req_side[0]), .req_approach(req_appr[0]), .req_station(req_stn[0][1:0]),
    .resp_valid(rv_p), .resp_granted(rg_p), .route_active(ra_p),
    .route_station(rs_p), .signal_clear(sc_p), .busy(busy_p)
  );

  route_interlock_ctrl #(
    .NUM_STATION(5), .NUM_APPROACH(2), .THROW_CYCLES(4), .RELEASE_CYCLES(3), .PREEMPT(0)
  ) dut_n (
    .CLOCK_50(clk), .RESET(rst),
    .req_valid(req_valid[1]), .req_ready(rdy_n), .req_cancel(req_cancel[1]),
    .req_side(req_side[1]), .req_approach(req_appr[1]), .req_station(req_stn[1]),
    .resp_valid(rv_n), .resp_granted(rg_n), .route_active(ra_n),
    .route_station(rs_n), .signal_clear(sc_n), .busy(busy_n)
  );

  typedef struct {
    logic g;
    int   t;
  } exp_t;

  exp_t q_p[$];
  exp_t q_n[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rv_p) begin
      if (q_p.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL resp_p_unexpected: got resp_valid at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = q_p.pop_front();
        chk("resp_p_granted", 32'(rg_p), 32'(e.g));
        chk("resp_p_cycle", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin
    if (rv_n) begin
      if (q_n.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL resp_n_unexpected: got resp_valid at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = q_n.pop_front();
        chk("resp_n_granted", 32'(rg_n), 32'(e.g));
        chk("resp_n_cycle", cyc, e.t);
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Issue one request; acc is the acceptance edge number.
  task automatic send(input int d, input logic canc, input logic side, input int ap, input int st,
                      input logic push, input logic g, input int lat, output int acc);
    int   n;
    logic r;
    exp_t e;
    n = 0;
    @(negedge clk);
    r = (d == 0) ? rdy_p : rdy_n;
    while (!r && n < 50) begin
      @(negedge clk);
      r = (d == 0) ? rdy_p : rdy_n;
      n++;
    end
    if (!r) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got req_ready=0 after 50 cycles, expected 1");
    end
    req_valid[d]  = 1'b1;
    req_cancel[d] = canc;
    req_side[d]   = side;
    req_appr[d]   = 1'(ap);
    req_stn[d]    = 3'(st);
    acc = cyc + 1;
    if (push) begin
      e.g = g;
      e.t = acc + lat;
      if (d == 0) q_p.push_back(e);
      else        q_n.push_back(e);
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    int acc;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_cancel[d] = 0; req_side[d] = 0; req_appr[d] = 0; req_stn[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_active", ra_p, 0);
    chk("rst_clear", sc_p, 0);
    chk("rst_station", rs_p, 0);
    chk("rst_ready", rdy_p, 1);
    chk("rst_busy", busy_p, 0);

    // 1: asynchronous reset mid-THROW discards the request
    send(0, 0, 0, 0, 0, 0, 0, 0, acc);
    wait_to(acc + 3);
    chk("s1_active_before", ra_p, 4'b0001);
    chk("s1_busy_before", busy_p, 1);
    #2 rst = 1'b1;
    #1;
    chk("s1_active_async", ra_p, 0);
    chk("s1_clear_async", sc_p, 0);
    chk("s1_station_async", rs_p, 0);
    chk("s1_resp_async", rv_p, 0);
    chk("s1_ready_async", rdy_p, 1);
    chk("s1_busy_async", busy_p, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // 2: clean set L0->S0
    send(0, 0, 0, 0, 0, 1, 1, 6, acc);
    wait_to(acc + 1);
    chk("s2_busy", busy_p, 1);
    chk("s2_active_c1", ra_p, 0);
    wait_to(acc + 2);
    chk("s2_active_c2", ra_p, 4'b0001);
    chk("s2_clear_c2", sc_p, 0);
    wait_to(acc + 5);
    chk("s2_clear_c5", sc_p, 0);
    wait_to(acc + 6);
    chk("s2_clear_c6", sc_p, 4'b0001);
    chk("s2_station", rs_p, 8'h00);

    // 3: non-conflicting L1->S2, then right side R0->S0
    send(0, 0, 0, 1, 2, 1, 1, 6, acc);
    wait_to(acc + 6);
    chk("s3_active_l1", ra_p, 4'b0011);
    chk("s3_station_l1", rs_p, 8'b00_00_10_00);
    send(0, 0, 1, 0, 0, 1, 1, 6, acc);
    wait_to(acc + 6);
    chk("s3_active_r0", ra_p, 4'b0111);
    chk("s3_clear_r0", sc_p, 4'b0111);

    // Idempotent set L0->S0
    send(0, 0, 0, 0, 0, 1, 1, 2, acc);
    wait_to(acc + 2);
    chk("idem_active", ra_p, 4'b0111);
    chk("idem_clear", sc_p, 4'b0111);

    // 4: preempting set L0->S3 kills L0->S0 and crossing L1->S2
    send(0, 0, 0, 0, 3, 1, 1, 9, acc);
    wait_to(acc + 1);
    chk("s4_clear_c1", sc_p, 4'b0111);
    wait_to(acc + 2);
    chk("s4_clear_c2", sc_p, 4'b0100);
    wait_to(acc + 4);
    chk("s4_active_c4", ra_p, 4'b0111);
    wait_to(acc + 5);
    chk("s4_active_c5", ra_p, 4'b0101);
    chk("s4_station_c5", rs_p[1:0], 3);
    wait_to(acc + 8);
    chk("s4_clear_c8", sc_p, 4'b0100);
    wait_to(acc + 9);
    chk("s4_clear_c9", sc_p, 4'b0101);

    // 6: set R1->S1, cancel it, cancel again
    send(0, 0, 1, 1, 1, 1, 1, 6, acc);
    wait_to(acc + 6);
    chk("s6_active_set", ra_p, 4'b1101);
    send(0, 1, 1, 1, 0, 1, 1, 5, acc);
    wait_to(acc + 2);
    chk("s6_clear_c2", sc_p, 4'b0101);
    wait_to(acc + 4);
    chk("s6_active_c4", ra_p, 4'b1101);
    wait_to(acc + 5);
    chk("s6_active_c5", ra_p, 4'b0101);
    send(0, 1, 1, 1, 0, 1, 0, 2, acc);
    wait_to(acc + 3);
    chk("s6_active_recancel", ra_p, 4'b0101);

    // 5: rejecting controller
    send(1, 0, 0, 0, 0, 1, 1, 6, acc);
    wait_to(acc + 6);
    send(1, 0, 0, 1, 2, 1, 1, 6, acc);
    wait_to(acc + 6);
    chk("s5_active_pre", ra_n, 4'b0011);
    send(1, 0, 0, 0, 3, 1, 0, 2, acc);
    wait_to(acc + 2);
    chk("s5_active", ra_n, 4'b0011);
    chk("s5_clear", sc_n, 4'b0011);
    chk("s5_station", rs_n, 12'b000_000_010_000);
    // L1->S4 conflicts with L1->S2 (same approach), rejected
    send(1, 0, 0, 1, 4, 1, 0, 2, acc);
    wait_to(acc + 2);
    // Station 5 out of range
    send(1, 0, 0, 0, 5, 1, 0, 2, acc);
    wait_to(acc + 3);
    chk("inv_active", ra_n, 4'b0011);

    repeat (5) @(negedge clk);
    chk("pending_p", q_p.size(), 0);
    chk("pending_n", q_n.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/route_interlock_ctrl.md
Name: route_interlock_ctrl

Overview:
Parametrised route-setting and interlocking controller for a station throat with NUM_APPROACH approach tracks per side (left/right) and NUM_STATION station tracks. Requests arrive through a valid/ready handshake. A sequential FSM does the following for each request:
- checks the request against active routes for conflicts;
- either preempts or rejects conflicting routes, per PREEMPT;
- applies approach locking before freeing a route;
- waits for the switch motors before clearing the signal.

It replaces the hard-wired 4-key/4-track interlock. The top level decodes the route table into switch/LED drive.

Parameters:
- NUM_STATION, 4, number of station tracks (>=2)
- NUM_APPROACH, 2, approach tracks per side (>=1)
- THROW_CYCLES, 50000000, cycles allowed for switches to move before signal clears (>=1)
- RELEASE_CYCLES, 100000000, approach-locking delay before a cancelled route is freed (>=1)
- PREEMPT, 1, 1 = conflicting routes are cancelled; 0 = conflicting request is rejected

Ports:
- CLOCK_50, in, 1, system clock
- RESET, in, 1, asynchronous active-high reset
- req_valid, in, 1, request present
- req_ready, out, 1, controller idle; a request is accepted on req_valid && req_ready
- req_cancel, in, 1, 1 = release route, 0 = set route
- req_side, in, 1, 0 = left, 1 = right
- req_approach, in, AW=$clog2(NUM_APPROACH) (min 1), approach index
- req_station, in, SW=$clog2(NUM_STATION), station index (ignored for cancel)
- resp_valid, out, 1, one-cycle response pulse
- resp_granted, out, 1, qualified by resp_valid
- route_active, out, 2*NUM_APPROACH, one bit per slot; slot = side*NUM_APPROACH + approach
- route_station, out, 2*NUM_APPROACH*SW, station index per slot
- signal_clear, out, 2*NUM_APPROACH, proceed aspect per slot
- busy, out, 1, equal to ~req_ready

Behaviour:
- Reset (asynchronous, any state):
  - FSM goes to IDLE; counter is cleared.
  - All route_active, route_station and signal_clear bits are 0.
  - resp_valid = 0, req_ready = 1.
  - Any in-flight request is discarded with no response.
- FSM states: IDLE, CHECK, RELEASE, THROW, RESP.
- IDLE:
  - req_ready = 1; the request fields are latched on acceptance; next state is CHECK.
  - req_valid is ignored while not in IDLE.
- CHECK (exactly 1 cycle):
  - Invalid request (approach >= NUM_APPROACH or station >= NUM_STATION): go to RESP, granted = 0.
  - Cancel of an inactive slot: go to RESP, granted = 0.
  - Cancel of an active slot: that slot's signal_clear drops at the CHECK->RELEASE edge; go to RELEASE with victim mask = that slot.
  - Set identical to an existing active route (same slot, same station): go to RESP, granted = 1, no throw, table unchanged.
  - Set, general case: compute the conflict mask over active slots on the same side.
    - Route (a,s) conflicts with (b,t) if a==b, or s==t, or (a<b && s>t), or (a>b && s<t) (crossing paths).
    - Empty mask: go to THROW.
    - Non-empty mask, PREEMPT = 0: go to RESP, granted = 0, table unchanged.
    - Non-empty mask, PREEMPT = 1: all victims' signal_clear drop at the edge; go to RELEASE.
- RELEASE (RELEASE_CYCLES cycles):
  - At exit, victim route_active bits clear.
  - Cancel requests then go to RESP, granted = 1.
  - Set requests then go to THROW.
- THROW (THROW_CYCLES cycles):
  - The requested slot's route_active and route_station are written on entry.
  - signal_clear for that slot stays 0 during THROW.
- RESP (1 cycle):
  - resp_valid = 1.
  - For a granted set, signal_clear of the slot rises on entry to RESP.
  - Then return to IDLE.
- Latency, in cycles from the acceptance edge to resp_valid high:
  - reject or idempotent set: 2
  - clean set: 2 + THROW_CYCLES
  - preempting set: 2 + RELEASE_CYCLES + THROW_CYCLES
  - cancel of an active slot: 2 + RELEASE_CYCLES
- Counter: width $clog2(max(THROW_CYCLES, RELEASE_CYCLES)+1); loaded on state entry; counts down; exits at 1. No wrap.
- Routes on opposite sides never conflict.
- Register outputs only; no combinational path from req_* to any output.

Decomposition:
- Package train_pkg holds:
  - side constants LEFT = 0, RIGHT = 1;
  - the FSM state enum;
  - slot-index and width helper functions.
- One sub-module, route_conflict_check: combinational; takes the route table plus the candidate route and outputs the conflict mask.

Test Plan:
Bench parameters: NUM_STATION=4, NUM_APPROACH=2, THROW_CYCLES=4, RELEASE_CYCLES=3.
1. Assert RESET mid-THROW -> all outputs 0 and req_ready = 1 immediately (asynchronous); no resp_valid follows.
2. From reset, set L0->S0 -> route_active[0] = 1 at cycle 2; resp_valid, granted = 1 and signal_clear[0] = 1 at cycle 6.
3. With L0->S0 active, set L1->S2 -> granted at cycle 6; route_active = 0b0011. Then set R0->S0 -> granted; the opposite side is unaffected.
4. PREEMPT=1, L1->S2 active, set L0->S3 (crossing path and same approach as L0->S0):
   - signal_clear[0] and signal_clear[1] drop at cycle 2;
   - both routes free at cycle 5;
   - slot 0 = S3 and granted at cycle 9.
5. Repeat scenario 4 with PREEMPT=0 -> resp_valid at cycle 2 with granted = 0; table and signal_clear unchanged.
6. Cancel R1 while active -> signal_clear[3] drops at cycle 2; route_active[3] clears and granted = 1 at cycle 5. Cancel R1 again -> granted = 0 at cycle 2. Request approach = 1 with station = 4 (with NUM_STATION = 5) -> granted = 0.
